mips_muldiv_seq: RTL and testbench

Iterative multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the MIPS core. It is started by the main decoder on MULT/MULTU/DIV/DIVU, runs a radix-2 shift-add or restoring-divide loop, and writes the result into HI/LO. It also serves MTHI/MTLO writes and MFHI/MFLO reads, and raises a stall to the pipeline while a result is still in flight.

---
 rtl/mips_muldiv_seq.sv | 207 ++++++++++++++++++++
 tb/tb_mips_muldiv_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq
//   Iterative multiply/divide sequencer that owns the MIPS HI/LO pair.
//   MULT/MULTU run a radix-2 shift-add loop, one multiplier bit per cycle.
//   DIV/DIVU run a restoring divide, one quotient bit per cycle. Signed
//   operations work on magnitudes, and the signs are applied in FIX.
//   The block also serves MTHI/MTLO writes. It raises stall while a result
//   is in flight and the pipeline wants HI/LO or the unit itself.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   start             begin an operation (sampled in IDLE only)
//   op_div, op_signed 0/1 = multiply/divide, unsigned/signed
//   rs_val, rt_val    multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata architectural writes to HI/LO (IDLE only)
//   read_hilo         MFHI/MFLO in decode
//   hi, lo            architectural HI/LO
//   busy              operation in flight
//   done              one-cycle pulse after HI/LO are updated by an operation
//   div_by_zero       one-cycle pulse with done for a divide by zero
//   stall             combinational hold request to the pipeline
module mips_muldiv_seq #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op_div,
  input  logic                  op_signed,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  read_hilo,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic                  stall
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]   hi_q, lo_q;
  logic           busy_q, done_q, dz_q;
  logic           is_div;
  logic           neg_res;   // negate product / quotient in FIX
  logic           neg_rem;   // negate remainder in FIX
  logic           zero_div;  // divide by zero: acc already holds the result
  logic [2*W-1:0] acc;
  logic [W-1:0]   shreg;     // multiplier (shifts right) or dividend (shifts left)
  logic [W-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [CW-1:0]  cnt;

  logic [W-1:0]   mag_rs, mag_rt;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_trial;
  logic           div_ge;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod;
  logic [W-1:0]   fix_hi, fix_lo;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
    return (sgn && v[W-1]) ? (~v + 1'b1) : v;
  endfunction

  assign mag_rs = magnitude(rs_val, op_signed);
  assign mag_rt = magnitude(rt_val, op_signed);

  // One iteration of each algorithm
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (shreg[0] ? opnd : {W{1'b0}})};
    mul_next  = {mul_sum, acc[W-1:1]};

    // The remainder shifted left can reach W+1 bits. When it is not smaller than
    // the divisor, the difference always fits back into W bits.
    div_trial = {acc[2*W-1:W], shreg[W-1]};
    div_ge    = (div_trial >= {1'b0, opnd});
    div_rem   = div_ge ? (div_trial[W-1:0] - opnd) : div_trial[W-1:0];
    div_next  = {div_rem, acc[W-2:0], div_ge};
  end

  // Sign fix-up of the final result
  always_comb begin
    prod   = neg_res ? (~acc + 1'b1) : acc;
    fix_hi = prod[2*W-1:W];
    fix_lo = prod[W-1:0];
    if (zero_div) begin
      fix_hi = acc[2*W-1:W];
      fix_lo = acc[W-1:0];
    end else if (is_div) begin
      fix_lo = neg_res ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
      fix_hi = neg_rem ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (op_div && (rt_val == '0)) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt == CW'(W - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      zero_div <= 1'b0;
      acc      <= '0;
      shreg    <= '0;
      opnd     <= '0;
      cnt      <= '0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_div  <= op_div;
            neg_res <= op_signed & (rs_val[W-1] ^ rt_val[W-1]);
            neg_rem <= op_signed & rs_val[W-1];
            cnt     <= '0;
            if (op_div && (rt_val == '0)) begin
              // The divide-by-zero result is loaded straight into acc, and FIX copies it out.
              zero_div <= 1'b1;
              acc      <= {rs_val, {W{1'b1}}};
              shreg    <= '0;
              opnd     <= '0;
            end else begin
              zero_div <= 1'b0;
              acc      <= '0;
              shreg    <= op_div ? mag_rs : mag_rt;
              opnd     <= op_div ? mag_rt : mag_rs;
            end
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc   <= div_next;
            shreg <= {shreg[W-2:0], 1'b0};
          end else begin
            acc   <= mul_next;
            shreg <= {1'b0, shreg[W-1:1]};
          end
        end
        S_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          dz_q   <= zero_div;
        end
        default: ;
      endcase
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign stall       = busy_q & (start | mthi | mtlo | read_hilo);

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Testbench for mips_muldiv_seq (DATA_WIDTH = 32).
// A transaction-level reference tracks architectural HI/LO and the remaining
// latency of the operation in flight. Results come from plain 64-bit arithmetic.
// A single compare process checks every cycle. It also services literal
// expectations that the directed stimulus posts for hand-computed cases.
module tb_mips_muldiv_seq;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0, op_div = 1'b0, op_signed = 1'b0;
  logic          mthi = 1'b0, mtlo = 1'b0, read_hilo = 1'b0;
  logic [W-1:0]  rs_val = '0, rt_val = '0, wdata = '0;
  logic [W-1:0]  hi, lo;
  logic          busy, done, div_by_zero, stall;

  mips_muldiv_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div), .op_signed(op_signed),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .read_hilo(read_hilo), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .stall(stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  function automatic logic [64:0] ref_op(input logic d, input logic s,
                                         input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    if (d && (b == 32'd0)) return {1'b1, a, 32'hFFFF_FFFF};
    if (!d) begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else begin
        p = {32'd0, a} * {32'd0, b};
      end
      return {1'b0, p};
    end
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  logic [W-1:0] m_hi, m_lo;
  int           m_rem;
  logic         m_done, m_dbz;
  logic [64:0]  m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_rem <= 0; m_done <= 1'b0; m_dbz <= 1'b0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_rem == 0) begin
        if (start) begin
          m_res <= ref_op(op_div, op_signed, rs_val, rt_val);
          m_rem <= (op_div && (rt_val == '0)) ? 1 : W + 1;
        end else begin
          if (mthi) m_hi <= wdata;
          if (mtlo) m_lo <= wdata;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
          m_dbz  <= m_res[64];
        end
      end
    end
  end

  // Literal expectations posted by the directed stimulus
  int          op_req = 0, op_ack = 0, op_n = 0, op_bc = 0;
  logic [31:0] op_hi, op_lo;
  logic        op_dbz;
  int          op_lat, op_busy;

  int          pt_req = 0, pt_ack = 0;
  logic [31:0] pt_hi, pt_lo;
  logic        pt_busy, pt_done, pt_stall;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp("hi", 64'(hi), 64'(m_hi));
      cmp("lo", 64'(lo), 64'(m_lo));
      cmp("busy", 64'(busy), 64'(m_rem != 0));
      cmp("done", 64'(done), 64'(m_done));
      cmp("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      cmp("stall", 64'(stall), 64'((m_rem != 0) && (start || mthi || mtlo || read_hilo)));
      if (pt_req != pt_ack) begin
        cmp("lit_hi", 64'(hi), 64'(pt_hi));
        cmp("lit_lo", 64'(lo), 64'(pt_lo));
        cmp("lit_busy", 64'(busy), 64'(pt_busy));
        cmp("lit_done", 64'(done), 64'(pt_done));
        cmp("lit_stall", 64'(stall), 64'(pt_stall));
        pt_ack = pt_req;
      end
      if (op_req != op_ack) begin
        op_n++;
        if (busy) op_bc++;
        if (done) begin
          cmp("op_hi", 64'(hi), 64'(op_hi));
          cmp("op_lo", 64'(lo), 64'(op_lo));
          cmp("op_dbz", 64'(div_by_zero), 64'(op_dbz));
          cmp("op_latency", 64'(op_n - 1), 64'(op_lat));
          cmp("op_busy_cycles", 64'(op_bc), 64'(op_busy));
          op_ack = op_req; op_n = 0; op_bc = 0;
        end else if (op_n > 300) begin
          cmp("op_done_within_bound", 64'(done), 64'(1));
          op_ack = op_req; op_n = 0; op_bc = 0;
        end
      end
    end
  end

  task automatic point(input logic [31:0] h, input logic [31:0] l,
                       input logic b, input logic d, input logic s);
    pt_hi = h; pt_lo = l; pt_busy = b; pt_done = d; pt_stall = s;
    pt_req++;
  endtask

  task automatic run_op(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic wm, input logic [31:0] wd,
                        input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic z;
    z = d && (b == 32'd0);
    op_hi = exp_hi; op_lo = exp_lo; op_dbz = z;
    op_lat = z ? 2 : W + 2;
    op_busy = z ? 1 : W + 1;
    op_req++;
    op_div = d; op_signed = s; rs_val = a; rt_val = b; mthi = wm; wdata = wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    point(hold_hi, hold_lo, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 320 && op_ack != op_req; k++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom % 16);
      5: return 32'hFFFF_FFF0 | 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2 rst_n = 1'b0;
    point(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // MULTU, MULT, DIV, DIVU by zero, DIV overflow
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0,
           32'd0, 32'd0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'd0,
           32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 32'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,
           32'd5, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // MTHI and MTLO together
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    point(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Hazard: read_hilo and an MTHI arrive while a MULT is in flight
    op_hi = 32'd0; op_lo = 32'd42; op_dbz = 1'b0; op_lat = W + 2; op_busy = W + 1; op_req++;
    op_div = 1'b0; op_signed = 1'b1; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    read_hilo = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    for (int j = 2; j <= int'(W); j++) begin
      if (j == 6) mthi = 1'b0;
      point(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    point(32'd0, 32'd42, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    read_hilo = 1'b0;

    // MTHI alone, then start together with mthi (the start wins)
    mthi = 1'b1; wdata = 32'h5555_AAAA;
    @(posedge clk); #1 mthi = 1'b0;
    point(32'h5555_AAAA, 32'd42, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_op(1'b0, 1'b0, 32'd2, 32'd3, 1'b1, 32'hFFFF_0000,
           32'h5555_AAAA, 32'd42, 32'd0, 32'd6);

    // Reset in the middle of a divide, then a clean DIVU
    op_div = 1'b1; op_signed = 1'b0; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    point(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 32'd0,
           32'd0, 32'd0, 32'd2, 32'd14);

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      start     = (($urandom % 5) == 0);
      op_div    = 1'($urandom);
      op_signed = 1'($urandom);
      rs_val    = pick();
      rt_val    = pick();
      mthi      = (($urandom % 8) == 0);
      mtlo      = (($urandom % 8) == 0);
      wdata     = $urandom;
      read_hilo = (($urandom % 4) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; read_hilo = 1'b0;
    repeat (W + 5) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
